conv_pool_engine: RTL and testbench
===================================

Name: conv_pool_engine

Overview:
- Convolution and pooling stage that sits directly downstream of the image/weight loader.
- Computes one output channel per start: a 5x5 valid convolution over the 28x28 image (24x24 result), then 2x2 max-pool (12x12), then ReLU.
- Streams 144 results per channel with the flattened index (channel*144 + py*12 + px) that the FC stage uses to address its 1152-entry weight vectors.
- Reads image and kernel words through 1-cycle-latency synchronous read ports.

Parameters:
- IMG_W, 28, image side length
- K, 5, kernel side length
- DW, 32, data/weight/result width (signed two's complement)
- FRAC, 16, fractional bits of the fixed-point format
- ACC_W, 72, accumulator width

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; synchronous, active-high
- start  in  1  begin a channel; sampled only in IDLE
- channel  in  3  kernel select 0..7; latched on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last output handshake
- pix_rd  out  1  pixel read strobe
- pix_addr  out  10  pixel address, row*28 + col
- pix_data  in  DW  pixel word, valid the cycle after pix_rd
- w_rd  out  1  weight read strobe
- w_addr  out  8  weight address, channel*25 + ky*5 + kx
- w_data  in  DW  signed weight, valid the cycle after w_rd
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_data  out  DW  pooled, ReLU'd result
- out_index  out  11  flattened FC index, 0..1151

Behaviour:
- Reset: all outputs 0, state IDLE, accumulators and counters cleared. Reset mid-operation aborts the channel; no partial done is produced.
- States:
  - IDLE: start=1 latches channel, clears py/px/q, goes to MAC, busy=1.
  - MAC: 25 cycles; tap t=0..24 (ky=t/5, kx=t%5) is issued with pix_rd=w_rd=1.
    - Pixel row = 2*py + dy + ky, column = 2*px + dx + kx, where sub-position q=0..3 gives dy=q[1], dx=q[0].
  - FLUSH: 2 cycles, no reads. Covers the data-return stage and the multiply-accumulate stage.
  - POOL: 1 cycle.
    - conv = sat_DW(acc >>> FRAC), arithmetic shift, saturate to [-2^31, 2^31-1].
    - q=0 loads the running max; q>0 takes max(running, conv). Accumulator clears.
    - q<3: q++ and return to MAC. q=3: go to OUT.
  - OUT:
    - out_valid=1, out_data = max(running, 0), out_index = channel*144 + py*12 + px.
    - Data and index stay stable until out_valid && out_ready.
    - On handshake: advance px (wrap at 12, then py++). If py wraps past 11, go to DONE; otherwise go to MAC.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Multiply: full DW x DW signed product (64b), sign-extended into ACC_W. 25 terms cannot overflow 72b.
- Timing with out_ready=1: 112 cycles per pooled output in MAC/FLUSH/POOL, plus 1 OUT cycle.
  - First out_valid appears 112 cycles after the start-accepting edge.
  - done appears 144*113 cycles after that edge.
- out_ready low: engine stalls in OUT with no reads issued.
- start while busy is ignored, and channel is not re-latched.
- The pixel word is treated as signed.
- No bias term.

Decomposition:
- Package cnn_pkg holds:
  - constants IMG_W=28, K=5, CONV_W=24, POOL_W=12, N_CH=8, FC_IN=1152, DW, FRAC;
  - state enum {IDLE, MAC, FLUSH, POOL, OUT, DONE};
  - function sat_dw.
- Sub-module conv_mac: registered product, ACC_W accumulator with clear/enable, shift+saturate output.
- Address generation and the FSM stay in the top module.

Test Plan:
- Ones: pixels=0x00010000, ch0 weights=0x00010000, out_ready=1.
  -> 144 outputs, all 0x00190000, indices 0..143, done once, busy low afterwards.
- Negative kernel: ch3 weights=0xFFFF0000, pixels=1.0.
  -> all out_data=0 (ReLU), indices 432..575.
- Ramp: pixel(r,c)=(r*28+c)<<16, ch0 weight tap0=1.0, other taps 0.
  -> index0=29<<16, index143=667<<16; max-pool picks the (odd,odd) pixel.
- Backpressure: out_ready low for 10 cycles at the first out_valid.
  -> out_data/out_index stable, pix_rd=w_rd=0 while stalled, done delayed by exactly 10 cycles.
- Saturation: pixels=0x7FFF0000, weights=0x7FFF0000.
  -> every out_data=0x7FFFFFFF.
- Reset/ignore: assert rst at cycle 500 of a ch0 run, then start ch1, and pulse start again mid-run.
  -> outputs 0 the cycle after rst; ch1 produces indices 144..287 exactly once; the second start has no effect.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants, FSM state encoding and the fixed-point saturation helper
// for the convolution/pooling stage.
package cnn_pkg;
    localparam int IMG_W  = 28;
    localparam int K      = 5;
    localparam int CONV_W = IMG_W - K + 1;
    localparam int POOL_W = CONV_W / 2;
    localparam int N_CH   = 8;
    localparam int FC_IN  = N_CH * POOL_W * POOL_W;
    localparam int DW     = 32;
    localparam int FRAC   = 16;
    localparam int ACC_W  = 72;
    localparam int CH_W   = $clog2(N_CH);
    localparam int IDX_W  = $clog2(FC_IN);
    localparam int PIX_AW = $clog2(IMG_W * IMG_W);
    localparam int W_AW   = $clog2(N_CH * K * K);

    typedef enum logic [2:0] {IDLE, MAC, FLUSH, POOL, OUT, DONE} state_t;

    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // Drop the fractional bits of the accumulator and clamp into DW signed range.
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> FRAC;
        if (sh > SAT_HI)      return SAT_HI[DW-1:0];
        else if (sh < SAT_LO) return SAT_LO[DW-1:0];
        else                  return sh[DW-1:0];
    endfunction
endpackage

// File: rtl/conv_pool_engine_if.sv
// Control, memory-read and result-stream signals of the conv/pool engine.
// Results use valid/ready: a word transfers on a clock edge where out_valid && out_ready; the engine holds data/index until then.
interface conv_pool_engine_if;
    import cnn_pkg::*;

    logic              start;
    logic [CH_W-1:0]   channel;
    logic              busy;
    logic              done;
    logic              pix_rd;
    logic [PIX_AW-1:0] pix_addr;
    logic [DW-1:0]     pix_data;
    logic              w_rd;
    logic [W_AW-1:0]   w_addr;
    logic [DW-1:0]     w_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [IDX_W-1:0]  out_index;
    state_t            fsm_state;

    modport master (
        input  start, channel, pix_data, w_data, out_ready,
        output busy, done, pix_rd, pix_addr, w_rd, w_addr,
               out_valid, out_data, out_index, fsm_state
    );
    modport slave (
        output start, channel, pix_data, w_data, out_ready,
        input  busy, done, pix_rd, pix_addr, w_rd, w_addr,
               out_valid, out_data, out_index, fsm_state
    );
endinterface

// File: rtl/conv_mac.sv
// Pipelined multiply-accumulate: registered signed product, wide accumulator,
// and a saturated fixed-point view of the accumulator.
module conv_mac
    import cnn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] conv
);
    logic signed [2*DW-1:0]  prod;
    logic                    prod_vld;
    logic signed [ACC_W-1:0] acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
        end else begin
            prod_vld <= en;
            if (en) prod <= a * b;
            if (clr)           acc <= '0;
            else if (prod_vld) acc <= acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        end
    end

    assign conv = sat_dw(acc);
endmodule

// File: rtl/conv_pool_engine.sv
// One output channel per start: 5x5 valid conv, 2x2 max-pool and ReLU, streamed
// as 144 indexed results. Each pooled output visits its four conv sub-positions in turn.
module conv_pool_engine
    import cnn_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    conv_pool_engine_if.master  bus
);
    localparam logic [2:0] KM1 = 3'(K - 1);
    localparam logic [3:0] PM1 = 4'(POOL_W - 1);

    state_t               state;
    logic [CH_W-1:0]      ch;
    logic [3:0]           py, px, py_n, px_n;
    logic [1:0]           q;
    logic [2:0]           ky, kx;
    logic                 fl;
    logic                 busy_r, done_r, rd_r, data_vld, ov_r;
    logic [PIX_AW-1:0]    pa_r;
    logic [W_AW-1:0]      wa_r;
    logic signed [DW-1:0] run_max, out_r, conv, pool_max;
    logic [IDX_W-1:0]     idx_r;
    logic                 mac_clr;

    function automatic logic [PIX_AW-1:0] pix_a(input logic [3:0] y, input logic [3:0] x,
                                                input logic [1:0] s, input logic [2:0] ty,
                                                input logic [2:0] tx);
        logic [PIX_AW-1:0] r, c;
        r = PIX_AW'({y, 1'b0}) + PIX_AW'(s[1]) + PIX_AW'(ty);
        c = PIX_AW'({x, 1'b0}) + PIX_AW'(s[0]) + PIX_AW'(tx);
        return r * PIX_AW'(IMG_W) + c;
    endfunction

    function automatic logic [W_AW-1:0] w_a(input logic [CH_W-1:0] c, input logic [2:0] ty,
                                            input logic [2:0] tx);
        return W_AW'(c) * W_AW'(K * K) + W_AW'(ty) * W_AW'(K) + W_AW'(tx);
    endfunction

    assign mac_clr  = (state == POOL);
    assign pool_max = (q == 2'd0 || conv > run_max) ? conv : run_max;
    assign px_n     = (px == PM1) ? 4'd0 : px + 4'd1;
    assign py_n     = (px != PM1) ? py : ((py == PM1) ? 4'd0 : py + 4'd1);

    conv_mac u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (mac_clr),
        .en   (data_vld),
        .a    (bus.pix_data),
        .b    (bus.w_data),
        .conv (conv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ch       <= '0;
            py       <= '0;
            px       <= '0;
            q        <= '0;
            ky       <= '0;
            kx       <= '0;
            fl       <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            rd_r     <= 1'b0;
            data_vld <= 1'b0;
            ov_r     <= 1'b0;
            pa_r     <= '0;
            wa_r     <= '0;
            run_max  <= '0;
            out_r    <= '0;
            idx_r    <= '0;
        end else begin
            // Read data returns one cycle after the strobe.
            data_vld <= rd_r;
            case (state)
                IDLE: if (bus.start) begin
                    ch     <= bus.channel;
                    py     <= '0;
                    px     <= '0;
                    q      <= '0;
                    ky     <= '0;
                    kx     <= '0;
                    busy_r <= 1'b1;
                    rd_r   <= 1'b1;
                    pa_r   <= '0;
                    wa_r   <= w_a(bus.channel, 3'd0, 3'd0);
                    state  <= MAC;
                end
                MAC: begin
                    if (kx == KM1) begin
                        kx <= '0;
                        if (ky == KM1) begin
                            ky    <= '0;
                            rd_r  <= 1'b0;
                            fl    <= 1'b0;
                            state <= FLUSH;
                        end else begin
                            ky   <= ky + 3'd1;
                            pa_r <= pix_a(py, px, q, ky + 3'd1, 3'd0);
                            wa_r <= w_a(ch, ky + 3'd1, 3'd0);
                        end
                    end else begin
                        kx   <= kx + 3'd1;
                        pa_r <= pix_a(py, px, q, ky, kx + 3'd1);
                        wa_r <= w_a(ch, ky, kx + 3'd1);
                    end
                end
                FLUSH: begin
                    fl <= 1'b1;
                    if (fl) state <= POOL;
                end
                POOL: begin
                    run_max <= pool_max;
                    if (q == 2'd3) begin
                        ov_r  <= 1'b1;
                        out_r <= pool_max[DW-1] ? '0 : pool_max;
                        idx_r <= IDX_W'(ch) * IDX_W'(POOL_W * POOL_W)
                               + IDX_W'(py) * IDX_W'(POOL_W) + IDX_W'(px);
                        state <= OUT;
                    end else begin
                        q     <= q + 2'd1;
                        rd_r  <= 1'b1;
                        pa_r  <= pix_a(py, px, q + 2'd1, 3'd0, 3'd0);
                        wa_r  <= w_a(ch, 3'd0, 3'd0);
                        state <= MAC;
                    end
                end
                OUT: if (bus.out_ready) begin
                    ov_r <= 1'b0;
                    px   <= px_n;
                    py   <= py_n;
                    q    <= '0;
                    if (px == PM1 && py == PM1) begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= DONE;
                    end else begin
                        rd_r  <= 1'b1;
                        pa_r  <= pix_a(py_n, px_n, 2'd0, 3'd0, 3'd0);
                        wa_r  <= w_a(ch, 3'd0, 3'd0);
                        state <= MAC;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.pix_rd    = rd_r;
    assign bus.pix_addr  = pa_r;
    assign bus.w_rd      = rd_r;
    assign bus.w_addr    = wa_r;
    assign bus.out_valid = ov_r;
    assign bus.out_data  = out_r;
    assign bus.out_index = idx_r;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_conv_pool_engine.sv
// Self-checking bench for conv_pool_engine: memory responders, a ready driver,
// a reference model filling expected queues, and a per-cycle compare process.
module tb_conv_pool_engine;
    import cnn_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_pool_engine_if bus();
    conv_pool_engine dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] pix_mem [784];
    logic [31:0] w_mem   [200];
    logic [31:0] exp_q[$];
    logic [10:0] exp_idx_q[$];

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int n_out, done_cnt, done_cyc, first_cyc, start_cyc, n_stall;
    int rdy_mode = 0, stall_cnt = 0;
    bit stalled_once = 0;
    logic [31:0] first_data, last_data, or_data, hold_data;
    logic [10:0] first_idx, last_idx, hold_idx;
    logic hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous read ports, one cycle latency
    always @(posedge clk) begin
        if (bus.pix_rd) bus.pix_data <= pix_mem[bus.pix_addr];
        if (bus.w_rd)   bus.w_data   <= w_mem[bus.w_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // reference: direct arithmetic over the image for every pooled output
    task automatic build_model(input int ch);
        logic signed [71:0] acc, p, w, sh;
        logic signed [31:0] conv, best;
        for (int py = 0; py < 12; py++) begin
            for (int px = 0; px < 12; px++) begin
                best = 0;
                for (int q = 0; q < 4; q++) begin
                    acc = 0;
                    for (int ky = 0; ky < 5; ky++) begin
                        for (int kx = 0; kx < 5; kx++) begin
                            p = $signed(pix_mem[(2*py + q/2 + ky)*28 + 2*px + q%2 + kx]);
                            w = $signed(w_mem[ch*25 + ky*5 + kx]);
                            acc += p * w;
                        end
                    end
                    sh = acc >>> 16;
                    if (sh > 72'sd2147483647)       conv = 32'h7FFFFFFF;
                    else if (sh < -72'sd2147483648) conv = 32'h80000000;
                    else                            conv = sh[31:0];
                    if (q == 0 || conv > best) best = conv;
                end
                exp_q.push_back(best < 0 ? 32'd0 : best);
                exp_idx_q.push_back(11'(ch*144 + py*12 + px));
            end
        end
    endtask

    // ready driver: 0 = always ready, 1 = random, 2 = one 10-cycle stall at first valid
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (stall_cnt > 0) begin
                        stall_cnt--;
                        if (stall_cnt == 0) bus.out_ready = 1'b1;
                    end else if (!stalled_once && bus.out_valid) begin
                        stalled_once = 1;
                        stall_cnt = 10;
                        bus.out_ready = 1'b0;
                    end
                end
            endcase
        end
    end

    // scoreboard and stall checks, sampled away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.out_valid && first_cyc < 0) first_cyc = cyc;
            if (hold) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, hold_data);
                chk("stall_index", bus.out_index, hold_idx);
                chk("stall_reads", {bus.pix_rd, bus.w_rd}, 0);
            end
            if (bus.out_valid && !bus.out_ready) n_stall++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got index %0d expected no output", bus.out_index);
                end else begin
                    chk("out_data", bus.out_data, exp_q.pop_front());
                    chk("out_index", bus.out_index, exp_idx_q.pop_front());
                end
                if (n_out == 0) begin
                    first_data = bus.out_data;
                    first_idx  = bus.out_index;
                end
                last_data = bus.out_data;
                last_idx  = bus.out_index;
                or_data   = or_data | bus.out_data;
                n_out++;
            end
            hold      = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
            hold_idx  = bus.out_index;
        end else begin
            hold = 1'b0;
        end
    end

    task automatic begin_channel(input int ch, input int mode);
        build_model(ch);
        n_out = 0; done_cnt = 0; first_cyc = -1; n_stall = 0; or_data = '0;
        rdy_mode = mode; stalled_once = 0; stall_cnt = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.channel = 3'(ch);
        @(posedge clk); #1;
        bus.start = 1'b0;
        start_cyc = cyc;
        @(negedge clk);
        chk("busy_after_start", bus.busy, 1);
    endtask

    task automatic run_ch(input int ch, input int mode, input bit mid_pulse, input bit timing);
        begin_channel(ch, mode);
        for (int i = 0; i < 40000 && done_cnt == 0; i++) begin
            @(posedge clk); #1;
            if (mid_pulse && i == 3000) begin
                bus.start = 1'b1;
                bus.channel = 3'd5;
            end else begin
                bus.start = 1'b0;
            end
        end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        repeat (4) @(negedge clk);
        chk("done_count", done_cnt, 1);
        chk("out_count", n_out, 144);
        chk("queue_empty", exp_q.size(), 0);
        chk("busy_after_done", bus.busy, 0);
        if (timing) begin
            chk("first_valid_latency", first_cyc - start_cyc, 112);
            chk("done_latency", done_cyc - start_cyc, 144*113 + ((mode == 2) ? 10 : 0));
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.channel = '0;
        for (int i = 0; i < 784; i++) pix_mem[i] = 32'h0;
        for (int i = 0; i < 200; i++) w_mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", bus.out_valid, 0);
        chk("reset_busy_done", {bus.busy, bus.done}, 0);
        chk("reset_reads", {bus.pix_rd, bus.w_rd}, 0);
        chk("reset_state", bus.fsm_state, IDLE);
        @(posedge clk); #1;
        rst = 1'b0;

        // all ones
        for (int i = 0; i < 784; i++) pix_mem[i] = 32'h00010000;
        for (int i = 0; i < 25; i++)  w_mem[i]   = 32'h00010000;
        run_ch(0, 0, 0, 1);
        chk("ones_first_data", first_data, 32'h00190000);
        chk("ones_last_data", last_data, 32'h00190000);
        chk("ones_first_idx", first_idx, 0);
        chk("ones_last_idx", last_idx, 143);

        // negative kernel on channel 3
        for (int i = 75; i < 100; i++) w_mem[i] = 32'hFFFF0000;
        run_ch(3, 0, 0, 0);
        chk("neg_all_zero", or_data, 0);
        chk("neg_first_idx", first_idx, 432);
        chk("neg_last_idx", last_idx, 575);

        // ramp image, single tap, with a 10-cycle stall on the first result
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) pix_mem[r*28 + c] = (r*28 + c) << 16;
        for (int i = 0; i < 25; i++) w_mem[i] = 32'h0;
        w_mem[0] = 32'h00010000;
        run_ch(0, 2, 0, 1);
        chk("ramp_first_data", first_data, 29 << 16);
        chk("ramp_last_data", last_data, 667 << 16);
        chk("stall_cycles", n_stall, 10);

        // saturation, random backpressure
        for (int i = 0; i < 784; i++) pix_mem[i] = 32'h7FFF0000;
        for (int i = 0; i < 25; i++)  w_mem[i]   = 32'h7FFF0000;
        run_ch(0, 1, 0, 0);
        chk("sat_first_data", first_data, 32'h7FFFFFFF);
        chk("sat_last_data", last_data, 32'h7FFFFFFF);

        // abort a channel-0 run with reset at cycle 500
        begin_channel(0, 0);
        repeat (498) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_busy_done", {bus.busy, bus.done}, 0);
        chk("abort_reads", {bus.pix_rd, bus.w_rd}, 0);
        chk("abort_data", bus.out_data, 0);
        chk("abort_index", bus.out_index, 0);
        chk("abort_addr", {bus.pix_addr, bus.w_addr}, 0);
        chk("abort_state", bus.fsm_state, IDLE);
        chk("abort_outputs_seen", n_out, 4);
        chk("abort_no_done", done_cnt, 0);
        exp_q.delete();
        exp_idx_q.delete();

        // random data on channel 1, random ready, ignored start mid-run
        for (int i = 0; i < 784; i++) pix_mem[i] = $urandom;
        for (int i = 0; i < 200; i++) w_mem[i]   = $urandom;
        run_ch(1, 1, 1, 0);
        chk("rand_first_idx", first_idx, 144);
        chk("rand_last_idx", last_idx, 287);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end
endmodule
